keccak_reg_driver: RTL and testbench

// Register-bus initiator that drives the keccak accelerator's register interface from a 32-bit word stream.
// It writes 50 state words to DIN, then pulses CTRL to start the permutation.
// It polls STATUS until done, then reads 50 DOUT words back onto an output stream.

---
 rtl/keccak_drv_pkg.sv | 44 ++++
 rtl/keccak_reg_driver.sv | 224 ++++++++++++++++++++++
 tb/tb_keccak_reg_driver.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_drv_pkg.sv
// keccak_drv_pkg: FSM state type, accelerator register map, job sizes and the
// default reg-bus request/response structs shared by keccak_reg_driver.
package keccak_drv_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DIN  = 3'd1,
    WR_CTRL = 3'd2,
    POLL    = 3'd3,
    RD_DOUT = 3'd4
  } drv_state_e;

  // Byte offsets of the accelerator registers relative to its base address.
  localparam logic [11:0] DIN_OFS    = 12'h000;
  localparam logic [11:0] DOUT_OFS   = 12'h0C8;
  localparam logic [11:0] CTRL_OFS   = 12'h190;
  localparam logic [11:0] STATUS_OFS = 12'h194;

  localparam int unsigned NUM_WORDS  = 50;
  localparam logic [5:0]  LAST_IDX   = 6'(NUM_WORDS - 1);
  localparam logic [15:0] POLL_LIMIT = 16'd1024;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } drv_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } drv_rsp_t;

  // Byte address of 32-bit word idx inside the register block at ofs.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [11:0] ofs,
                                            input logic [5:0]  idx);
    return base + {20'd0, ofs} + {24'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/keccak_reg_driver.sv
// keccak_reg_driver: reg-bus initiator that loads 50 state words into the
// keccak accelerator, starts it, polls STATUS, then streams 50 DOUT words out.
// Optional feature macro: KECCAK_DRV_POLL_TIMEOUT_EN (bounded STATUS polling).
module keccak_reg_driver
  import keccak_drv_pkg::*;
#(
  parameter type         reg_req_t = drv_req_t,
  parameter type         reg_rsp_t = drv_rsp_t,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [31:0] out_data_o,
  input  logic        out_ready_i,
  output reg_req_t    reg_req_o,
  input  reg_rsp_t    reg_rsp_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  drv_state_e  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        req_write_q, req_write_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        beat_done_s, beat_err_s, in_ready_s;
  logic [5:0]  idx_inc_s;
`ifdef KECCAK_DRV_POLL_TIMEOUT_EN
  logic [15:0] poll_cnt_q, poll_cnt_d;
`endif

  // Next-state, bus-beat sequencing and stream handshakes.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_write_d = req_write_q;
    req_wdata_d = req_wdata_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    err_d       = err_q;
    in_ready_s  = 1'b0;
`ifdef KECCAK_DRV_POLL_TIMEOUT_EN
    poll_cnt_d  = poll_cnt_q;
`endif
    beat_done_s = req_valid_q & reg_rsp_i.ready;
    beat_err_s  = req_valid_q & reg_rsp_i.error;
    idx_inc_s   = (idx_q == LAST_IDX) ? 6'd0 : idx_q + 6'd1;

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = WR_DIN;
        end else begin
          state_d = IDLE;
        end
      end
      WR_DIN: begin
        if (beat_done_s) begin
          idx_d = idx_inc_s;
          if (idx_q == LAST_IDX) begin
            // Last DIN word landed: kick the permutation straight away.
            state_d     = WR_CTRL;
            req_valid_d = 1'b1;
            req_write_d = 1'b1;
            req_wdata_d = 32'h0000_0001;
            req_addr_d  = word_addr(BASE_ADDR, CTRL_OFS, 6'd0);
          end else begin
            // A completing beat frees the slot, so a new word can be taken now.
            req_valid_d = 1'b0;
            in_ready_s  = ~beat_err_s;
          end
        end else begin
          in_ready_s = ~req_valid_q;
        end
        if (in_ready_s && in_valid_i) begin
          req_valid_d = 1'b1;
          req_write_d = 1'b1;
          req_wdata_d = in_data_i;
          req_addr_d  = word_addr(BASE_ADDR, DIN_OFS, idx_d);
        end
      end
      WR_CTRL: begin
        if (beat_done_s) begin
          state_d     = POLL;
          req_valid_d = 1'b1;
          req_write_d = 1'b0;
          req_wdata_d = 32'h0000_0000;
          req_addr_d  = word_addr(BASE_ADDR, STATUS_OFS, 6'd0);
`ifdef KECCAK_DRV_POLL_TIMEOUT_EN
          poll_cnt_d  = 16'd0;
`endif
        end else begin
          state_d = WR_CTRL;
        end
      end
      POLL: begin
        if (beat_done_s) begin
          if (reg_rsp_i.rdata[0]) begin
            state_d    = RD_DOUT;
            req_addr_d = word_addr(BASE_ADDR, DOUT_OFS, idx_q);
          end else begin
            // req_valid stays high: the next STATUS read goes out next cycle.
`ifdef KECCAK_DRV_POLL_TIMEOUT_EN
            poll_cnt_d = poll_cnt_q + 16'd1;
            if (poll_cnt_d == POLL_LIMIT) begin
              err_d       = 1'b1;
              req_valid_d = 1'b0;
              idx_d       = 6'd0;
              state_d     = IDLE;
            end else begin
              state_d = POLL;
            end
`else
            state_d = POLL;
`endif
          end
        end else begin
          state_d = POLL;
        end
      end
      RD_DOUT: begin
        if (beat_done_s) begin
          out_data_d  = reg_rsp_i.rdata;
          out_valid_d = 1'b1;
          req_valid_d = 1'b0;
        end else if (out_valid_q && out_ready_i) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            idx_d   = 6'd0;
            state_d = IDLE;
          end else begin
            idx_d       = idx_inc_s;
            req_valid_d = 1'b1;
            req_write_d = 1'b0;
            req_addr_d  = word_addr(BASE_ADDR, DOUT_OFS, idx_inc_s);
          end
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      default: begin
        state_d     = IDLE;
        req_valid_d = 1'b0;
      end
    endcase

    // A bus error abandons the job wherever it is; nothing more is streamed.
    if (beat_err_s) begin
      state_d     = IDLE;
      idx_d       = 6'd0;
      req_valid_d = 1'b0;
      out_valid_d = 1'b0;
      err_d       = 1'b1;
      in_ready_s  = 1'b0;
    end else begin
      err_d = err_d | err_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= 6'd0;
      req_valid_q <= 1'b0;
      req_addr_q  <= 32'h0;
      req_write_q <= 1'b0;
      req_wdata_q <= 32'h0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef KECCAK_DRV_POLL_TIMEOUT_EN
      poll_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_write_q <= req_write_d;
      req_wdata_q <= req_wdata_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef KECCAK_DRV_POLL_TIMEOUT_EN
      poll_cnt_q  <= poll_cnt_d;
`endif
    end
  end

  // Bus request assembled from the beat registers; all byte lanes enabled.
  always_comb begin
    reg_req_o       = '0;
    reg_req_o.addr  = req_addr_q;
    reg_req_o.write = req_write_q;
    reg_req_o.wdata = req_wdata_q;
    reg_req_o.wstrb = 4'hF;
    reg_req_o.valid = req_valid_q;
  end

  assign in_ready_o  = in_ready_s;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_keccak_reg_driver.sv
// tb_keccak_reg_driver: directed bench for keccak_reg_driver with a simple
// reg-bus slave model (configurable wait states, STATUS delay, error beat).
module tb_keccak_reg_driver;
  import keccak_drv_pkg::*;

  localparam logic [31:0] BASE     = 32'h4000_0000;
  localparam logic [31:0] DIN_A    = 32'h4000_0000;
  localparam logic [31:0] DOUT_A   = 32'h4000_00C8;
  localparam logic [31:0] CTRL_A   = 32'h4000_0190;
  localparam logic [31:0] STATUS_A = 32'h4000_0194;

  logic        clk, rst_i, in_valid_i, out_ready_i;
  logic [31:0] in_data_i;
  logic        in_ready_o, out_valid_o, busy_o, done_o, err_o;
  logic [31:0] out_data_o;
  drv_req_t    req_s;
  drv_rsp_t    rsp_s;

  int n_assert, n_fail;
  int wait_cycles, status_zero, status_base, err_beat;
  int wait_cnt, status_reads, log_n, stall_cycles, stall_changes, done_cnt, wstrb_bad;
  logic [31:0] log_addr  [0:4095];
  logic        log_write [0:4095];
  logic [31:0] log_wdata [0:4095];
  logic        prev_stall;
  drv_req_t    prev_req;

  keccak_reg_driver #(.reg_req_t(drv_req_t), .reg_rsp_t(drv_rsp_t), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .in_ready_o(in_ready_o), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
    .out_ready_i(out_ready_i), .reg_req_o(req_s), .reg_rsp_i(rsp_s),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave response: ready after wait_cycles stall cycles, DOUT word k reads as ~k.
  always_comb begin
    rsp_s       = '0;
    rsp_s.ready = req_s.valid && (wait_cnt == wait_cycles);
    if (req_s.addr == STATUS_A) rsp_s.rdata = ((status_reads - status_base) >= status_zero) ? 32'h1 : 32'h0;
    else if (req_s.addr >= DOUT_A && req_s.addr < CTRL_A) rsp_s.rdata = ~((req_s.addr - DOUT_A) >> 2);
    else rsp_s.rdata = 32'hDEAD_BEEF;
    rsp_s.error = rsp_s.ready && req_s.write && (err_beat >= 0) && (req_s.addr == DIN_A + 32'(err_beat) * 32'd4);
  end

  // Slave bookkeeping: wait counter, completed-beat log, stall stability monitor.
  always @(posedge clk) begin
    if (rst_i) begin
      wait_cnt   <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (req_s.valid && !rsp_s.ready) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
      if (rsp_s.ready) begin
        log_addr[log_n[11:0]]  <= req_s.addr;
        log_write[log_n[11:0]] <= req_s.write;
        log_wdata[log_n[11:0]] <= req_s.wdata;
        log_n <= log_n + 1;
        if (req_s.addr == STATUS_A && !req_s.write) status_reads <= status_reads + 1;
      end
      if (req_s.valid && req_s.wstrb != 4'hF) wstrb_bad <= wstrb_bad + 1;
      if (prev_stall && req_s != prev_req) stall_changes <= stall_changes + 1;
      if (req_s.valid && !rsp_s.ready) stall_cycles <= stall_cycles + 1;
      prev_stall <= req_s.valid && !rsp_s.ready;
      prev_req   <= req_s;
    end
  end

  // Count done pulses.
  always @(negedge clk) begin
    if (done_o) done_cnt <= done_cnt + 1;
  end

  // Hard stop if something hangs despite the bounded loops.
  initial begin
    #600000;
    $display("FAIL watchdog: observed no end of test, expected $finish before 600000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic feed(input int nwords);
    int k = 0;
    int guard = 0;
    logic hs;
    while (k < nwords && guard < 2000) begin
      in_valid_i = 1'b1;
      in_data_i  = 32'(k);
      #1;
      hs = in_ready_o;
      @(negedge clk);
      guard++;
      if (hs) k++;
    end
    in_valid_i = 1'b0;
    chk("feed_count", 32'(k), 32'(nwords));
  endtask

  task automatic collect(input int nwords, input int stall_word, input int stall_len);
    int k = 0;
    int guard = 0;
    int left = stall_len;
    int mark = 0;
    out_ready_i = 1'b1;
    while (k < nwords && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (out_valid_o) begin
        if (k == stall_word && left > 0) begin
          if (left == stall_len) mark = log_n;
          out_ready_i = 1'b0;
          left--;
          chk("held_data", out_data_o, ~32'(k));
          if (left == 0) begin
            chk("no_read_in_stall", 32'(log_n), 32'(mark));
            chk("req_idle_in_stall", {31'd0, req_s.valid}, 32'd0);
          end
        end else begin
          out_ready_i = 1'b1;
          chk($sformatf("out_word_%0d", k), out_data_o, ~32'(k));
          k++;
        end
      end else begin
        out_ready_i = 1'b1;
      end
    end
    chk("out_count", 32'(k), 32'(nwords));
  endtask

  task automatic chk_log(input int start, input int nstat);
    int i = start;
    for (int k = 0; k < 50; k++) begin
      chk($sformatf("din_addr_%0d", k), log_addr[12'(i)], DIN_A + 32'(k) * 32'd4);
      chk($sformatf("din_wr_%0d", k), {31'd0, log_write[12'(i)]}, 32'd1);
      chk($sformatf("din_data_%0d", k), log_wdata[12'(i)], 32'(k));
      i++;
    end
    chk("ctrl_addr", log_addr[12'(i)], CTRL_A);
    chk("ctrl_wr", {31'd0, log_write[12'(i)]}, 32'd1);
    chk("ctrl_data", log_wdata[12'(i)], 32'h1);
    i++;
    for (int s = 0; s < nstat; s++) begin
      chk($sformatf("status_addr_%0d", s), log_addr[12'(i)], STATUS_A);
      chk($sformatf("status_rd_%0d", s), {31'd0, log_write[12'(i)]}, 32'd0);
      i++;
    end
    for (int k = 0; k < 50; k++) begin
      chk($sformatf("dout_addr_%0d", k), log_addr[12'(i)], DOUT_A + 32'(k) * 32'd4);
      chk($sformatf("dout_rd_%0d", k), {31'd0, log_write[12'(i)]}, 32'd0);
      i++;
    end
    chk("beat_total", 32'(log_n - start), 32'(101 + nstat));
  endtask

  int start, done_base, chg_base, stall_base;

  initial begin
    n_assert = 0; n_fail = 0;
    rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = 32'h0; out_ready_i = 1'b0;
    wait_cycles = 0; status_zero = 0; status_base = 0; err_beat = -1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_out_data", out_data_o, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_req_valid", {31'd0, req_s.valid}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Job A: zero-wait slave, STATUS ready on first read
    start = log_n; done_base = done_cnt; status_base = status_reads; status_zero = 0;
    feed(50);
    collect(50, -1, 0);
    @(negedge clk);
    chk("a_done_pulse", {31'd0, done_o}, 32'd1);
    chk("a_busy_after", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    chk("a_done_low", {31'd0, done_o}, 32'd0);
    chk("a_done_count", 32'(done_cnt - done_base), 32'd1);
    chk("a_err", {31'd0, err_o}, 32'd0);
    chk_log(start, 1);

    // Job B: 3 wait cycles per beat, 7 busy STATUS reads, sink stalls on word 10
    start = log_n; done_base = done_cnt; chg_base = stall_changes; stall_base = stall_cycles;
    wait_cycles = 3; status_base = status_reads; status_zero = 7;
    feed(50);
    collect(50, 10, 5);
    repeat (3) @(negedge clk);
    chk("b_done_count", 32'(done_cnt - done_base), 32'd1);
    chk("b_stalls_seen", {31'd0, (stall_cycles - stall_base) > 0}, 32'd1);
    chk("b_req_stable", 32'(stall_changes - chg_base), 32'd0);
    chk_log(start, 8);
    wait_cycles = 0;

    // Job C: error response on DIN beat 20
    start = log_n; done_base = done_cnt; status_base = status_reads; status_zero = 0; err_beat = 20;
    feed(21);
    @(negedge clk);
    chk("c_err_set", {31'd0, err_o}, 32'd1);
    chk("c_busy_clear", {31'd0, busy_o}, 32'd0);
    chk("c_in_ready", {31'd0, in_ready_o}, 32'd0);
    chk("c_req_dropped", {31'd0, req_s.valid}, 32'd0);
    repeat (5) @(negedge clk);
    chk("c_no_more_beats", 32'(log_n - start), 32'd21);
    chk("c_err_sticky", {31'd0, err_o}, 32'd1);
    chk("c_no_out", {31'd0, out_valid_o}, 32'd0);
    chk("c_no_done", 32'(done_cnt - done_base), 32'd0);
    err_beat = -1;

    // Job D: reset clears err, then reset in the middle of RD_DOUT
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    chk("d_err_cleared", {31'd0, err_o}, 32'd0);
    status_base = status_reads; status_zero = 0;
    feed(50);
    collect(5, -1, 0);
    chk("d_busy_mid", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    chk("d_rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("d_rst_out_data", out_data_o, 32'd0);
    chk("d_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("d_rst_done", {31'd0, done_o}, 32'd0);
    chk("d_rst_err", {31'd0, err_o}, 32'd0);
    chk("d_rst_in_ready", {31'd0, in_ready_o}, 32'd0);
    chk("d_rst_req_valid", {31'd0, req_s.valid}, 32'd0);
    chk("d_rst_req_addr", req_s.addr, 32'd0);
    rst_i = 1'b0;
    start = log_n;
    repeat (4) @(negedge clk);
    chk("d_idle_after_rst", 32'(log_n - start), 32'd0);
    chk("d_wstrb_always_f", 32'(wstrb_bad), 32'd0);

`ifdef KECCAK_DRV_POLL_TIMEOUT_EN
    // Job E: STATUS never completes -> timeout after 1024 reads
    begin
      int guard = 0;
      int nstat = 0;
      int ndout = 0;
      start = log_n; status_base = status_reads; status_zero = 32'h4000_0000;
      feed(50);
      while (!err_o && guard < 3000) begin
        @(negedge clk);
        guard++;
      end
      chk("e_timeout_err", {31'd0, err_o}, 32'd1);
      chk("e_busy_clear", {31'd0, busy_o}, 32'd0);
      for (int i = start; i < log_n; i++) begin
        if (log_addr[12'(i)] == STATUS_A) nstat++;
        if (log_addr[12'(i)] >= DOUT_A && log_addr[12'(i)] < CTRL_A) ndout++;
      end
      chk("e_status_reads", 32'(nstat), 32'd1024);
      chk("e_no_dout", 32'(ndout), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
